shift_reg_univ: RTL and testbench
=================================

// Module: shift_reg_univ
// PURPOSE
//   Parametrised universal shift register: WIDTH-bit bank of D flip-flops with
//   hold, shift-right, shift-left and parallel-load modes, serial in/out at both ends.
//   A shift counter flags each complete WIDTH-bit serialisation.
//   Serves as the generic serialiser/deserialiser and storage register for sequential datapaths.
// PARAMETERS
//   WIDTH    8   register width in bits; legal range >= 2
//   RST_VAL  0   WIDTH-bit value loaded into q_out on reset
// PORTS
//   clk        in   1                  rising-edge clock
//   rst_n      in   1                  asynchronous reset, active low
//   mode_in    in   2                  00 hold, 01 shift right, 10 shift left, 11 parallel load
//   par_in     in   WIDTH              parallel load data
//   sr_in      in   1                  serial input, enters at MSB on shift right
//   sl_in      in   1                  serial input, enters at LSB on shift left
//   q_out      out  WIDTH              register contents
//   sr_out     out  1                  q_out[0], the bit leaving on shift right
//   sl_out     out  1                  q_out[WIDTH-1], the bit leaving on shift left
//   cnt_out    out  $clog2(WIDTH)      shifts completed since last load/wrap
//   done_out   out  1                  one-cycle pulse, WIDTH shifts completed
//   clr_in     in   1                  only when SYNC_CLR_EN is defined; see CONFIGURATION
// BEHAVIOUR
//   - Reset: rst_n low clears immediately, independent of clk. q_out=RST_VAL, cnt_out=0, done_out=0.
//     Reset may assert at any point, including mid-shift; release takes effect at the next rising edge.
//   - All state updates on the rising clk edge. Latency is one cycle from mode_in/data to q_out.
//   - Hold (00): q_out, cnt_out unchanged.
//   - Shift right (01): q_out <= {sr_in, q_out[WIDTH-1:1]}.
//   - Shift left (10): q_out <= {q_out[WIDTH-2:0], sl_in}.
//   - Load (11): q_out <= par_in; cnt_out <= 0; done_out <= 0.
//   - sr_out/sl_out are combinational taps of the registered q_out (no extra delay).
//   - Counter: each shift cycle (01 or 10, directions mixed freely) increments cnt_out.
//     On the shift at which cnt_out==WIDTH-1, cnt_out wraps to 0 and done_out=1 for exactly
//     that following cycle. Any non-wrapping cycle drives done_out=0.
//   - Hold does not reset the counter; shift runs may be interrupted by hold.
//   - Clock-edge state machine: IDLE (cnt=0) -> SHIFTING (cnt 1..WIDTH-1) -> wrap -> IDLE+done.
//     A load from any state returns to IDLE without a done pulse.
//   - No X propagation: mode_in is fully decoded; all four encodings are defined.
// CONFIGURATION
//   SYNC_CLR_EN defined: port clr_in exists. clr_in=1 at an edge sets q_out=RST_VAL,
//     cnt_out=0, done_out=0. Priority over every mode_in value; async rst_n still overrides all.
//   SYNC_CLR_EN undefined: no clr_in port; behaviour exactly as above.
// TESTING (WIDTH=8, RST_VAL=0, clock period 10 ns, stimulus changes away from rising edges)
//   1. rst_n=0 for 2 cycles, mode_in=11, par_in=FF -> q_out=00, cnt_out=0, done_out=0 throughout.
//   2. Load A5, then hold 3 cycles -> q_out=A5 each cycle, cnt_out=0.
//   3. Load A5, shift right 8 cycles with sr_in=0 ->
//      sr_out before each edge = 1,0,1,0,0,1,0,1.
//      q_out=00 after 8 shifts, done_out high for 1 cycle after 8th edge, cnt_out=0.
//   4. Load 00, shift left 8 cycles with sl_in = 1,1,0,0,1,0,1,1 -> q_out=CB, done_out pulses once.
//   5. Load 3C, shift 4 cycles, hold 2, shift 4 -> cnt_out 1,2,3,4,4,4,5,6,7,0. done_out only on final.
//   6. Mid-shift (cnt_out=5), assert rst_n half-way between edges for 2 cycles ->
//      q_out=00, cnt_out=0 immediately. First shift after release gives cnt_out=1.
//      SYNC_CLR_EN build: clr_in=1 with mode_in=11, par_in=FF -> q_out=00.
//   Randomised mode/data runs checked against a behavioural reference model.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register (hold / shift right / shift left / load) with wrap counter.
// Define SYNC_CLR_EN to add the synchronous clear input clr_in.
module shift_reg_univ #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
`ifdef SYNC_CLR_EN
   input  logic                     clr_in,
`endif
   input  logic [1:0]               mode_in,
   input  logic [WIDTH-1:0]         par_in,
   input  logic                     sr_in,
   input  logic                     sl_in,
   output logic [WIDTH-1:0]         q_out,
   output logic                     sr_out,
   output logic                     sl_out,
   output logic [$clog2(WIDTH)-1:0] cnt_out,
   output logic                     done_out
);

   localparam int unsigned CntW = $clog2(WIDTH);

   localparam logic [1:0] ModeHold  = 2'b00;
   localparam logic [1:0] ModeShr   = 2'b01;
   localparam logic [1:0] ModeShl   = 2'b10;
   localparam logic [1:0] ModeLoad  = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shift_en;

   always_comb begin
      q_d      = q_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      shift_en = 1'b0;

      unique case (mode_in)
         ModeHold: ;
         ModeShr: begin
            q_d      = {sr_in, q_q[WIDTH-1:1]};
            shift_en = 1'b1;
         end
         ModeShl: begin
            q_d      = {q_q[WIDTH-2:0], sl_in};
            shift_en = 1'b1;
         end
         ModeLoad: begin
            q_d   = par_in;
            cnt_d = '0;
         end
         default: ;
      endcase

      // Counter is direction-agnostic; wrap marks a full WIDTH-bit serialisation.
      if (shift_en) begin
         if (cnt_q == CntW'(WIDTH - 1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end

`ifdef SYNC_CLR_EN
      if (clr_in) begin
         q_d    = RST_VAL;
         cnt_d  = '0;
         done_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= RST_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q_out    = q_q;
   assign sr_out   = q_q[0];
   assign sl_out   = q_q[WIDTH-1];
   assign cnt_out  = cnt_q;
   assign done_out = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: directed scenarios plus randomised modes,
// checked against an arithmetic reference model.
module tb_shift_reg_univ;

   localparam int W  = 8;
   localparam int CW = $clog2(W);

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    mode  = 2'b11;
   logic [W-1:0]  par   = '1;
   logic          sr    = 1'b0;
   logic          sl    = 1'b0;
   logic [W-1:0]  q;
   logic          sro;
   logic          slo;
   logic [CW-1:0] cnt;
   logic          done;
`ifdef SYNC_CLR_EN
   logic          clr   = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] q;
      int           cnt;
      logic         done;
   } exp_t;

   exp_t sb[$];

   logic [W-1:0] m_q    = '0;
   int           m_cnt  = 0;
   logic         m_done = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   shift_reg_univ #(
      .WIDTH   (W),
      .RST_VAL ('0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef SYNC_CLR_EN
      .clr_in   (clr),
`endif
      .mode_in  (mode),
      .par_in   (par),
      .sr_in    (sr),
      .sl_in    (sl),
      .q_out    (q),
      .sr_out   (sro),
      .sl_out   (slo),
      .cnt_out  (cnt),
      .done_out (done)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_q    = '0;
      m_cnt  = 0;
      m_done = 1'b0;
   endfunction

   // Drive one cycle of stimulus at the falling edge and queue the state expected after the next
   // rising edge.
   task automatic step(input logic [1:0] md, input logic [W-1:0] pd, input logic s_r,
                       input logic s_l, input logic cl);
      exp_t e;
      logic sh;
      @(negedge clk);
      mode = md;
      par  = pd;
      sr   = s_r;
      sl   = s_l;
`ifdef SYNC_CLR_EN
      clr  = cl;
`endif
      m_done = 1'b0;
      sh     = 1'b0;
      if (cl) begin
         model_reset();
      end else if (md == 2'd1) begin
         m_q = (m_q >> 1) | ({{(W-1){1'b0}}, s_r} << (W - 1));
         sh  = 1'b1;
      end else if (md == 2'd2) begin
         m_q = (m_q << 1) | {{(W-1){1'b0}}, s_l};
         sh  = 1'b1;
      end else if (md == 2'd3) begin
         m_q   = pd;
         m_cnt = 0;
      end
      if (sh) begin
         m_cnt = m_cnt + 1;
         if (m_cnt == W) begin
            m_cnt  = 0;
            m_done = 1'b1;
         end
      end
      e.q    = m_q;
      e.cnt  = m_cnt;
      e.done = m_done;
      sb.push_back(e);
   endtask

   // Monitor: the register presents a new state after every rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("q_out", 32'(q), 32'(e.q));
         check("cnt_out", 32'(cnt), 32'(e.cnt));
         check("done_out", 32'(done), 32'(e.done));
         check("sr_out", 32'(sro), 32'(e.q[0]));
         check("sl_out", 32'(slo), 32'(e.q[W-1]));
      end
   end

   initial begin
      logic [W-1:0] sr_pre;
      logic [W-1:0] sl_seq;
      int           r;

      // Reset held with a pending load of FF: nothing may change.
      #1;
      check("rst_q0", 32'(q), 32'h00);
      repeat (2) begin
         @(negedge clk);
         check("rst_q", 32'(q), 32'h00);
         check("rst_cnt", 32'(cnt), 0);
         check("rst_done", 32'(done), 0);
      end
      #2;
      rst_n = 1'b1;
      model_reset();

      // Load then hold.
      step(2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
      repeat (3) step(2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("hold_q", 32'(q), 32'hA5);

      // Serialise A5 out of the LSB end.
      step(2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
      sr_pre = 8'hA5;
      for (int i = 0; i < W; i++) begin
         step(2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
         check("sr_out_pre", 32'(sro), 32'(sr_pre[i]));
      end
      @(posedge clk); #1;
      check("shr_q", 32'(q), 32'h00);
      check("shr_done", 32'(done), 1);
      check("shr_cnt", 32'(cnt), 0);

      // Deserialise through the LSB on shift left.
      sl_seq = 8'b1100_1011;
      step(2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < W; i++) step(2'b10, 8'h00, 1'b0, sl_seq[W-1-i], 1'b0);
      @(posedge clk); #1;
      check("shl_q", 32'(q), 32'hCB);
      check("shl_done", 32'(done), 1);

      // Shift run interrupted by hold.
      step(2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
      repeat (4) step(2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      repeat (2) step(2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("hold_cnt", 32'(cnt), 4);
      check("hold_done", 32'(done), 0);
      repeat (4) step(2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("mix_cnt", 32'(cnt), 0);
      check("mix_done", 32'(done), 1);

      // Asynchronous reset between edges, mid-shift.
      step(2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
      repeat (5) step(2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("pre_rst_cnt", 32'(cnt), 5);
      @(negedge clk);
      mode  = 2'b00;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_q", 32'(q), 32'h00);
      check("async_cnt", 32'(cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_q", 32'(q), 32'h00);
      rst_n = 1'b1;
      step(2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("post_rst_cnt", 32'(cnt), 1);

`ifdef SYNC_CLR_EN
      step(2'b11, 8'h77, 1'b0, 1'b0, 1'b0);
      step(2'b11, 8'hFF, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("clr_q", 32'(q), 32'h00);
      step(2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

      // Randomised run, weighted towards shifting so the counter wraps often.
      for (int i = 0; i < 400; i++) begin
         logic [1:0] md;
         r  = int'($urandom_range(0, 9));
         md = (r == 0) ? 2'b00 : (r <= 4) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
`ifdef SYNC_CLR_EN
         step(md, W'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
`else
         step(md, W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
`endif
      end

      repeat (2) @(posedge clk);
      #2;
      check("sb_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
